// File: rtl/i2c_reg_slave_if.sv
// Pad-side I2C signals of i2c_reg_slave: SCL/SDA inputs and the open-drain SDA enable.
// The master modport is the bus/pad model side, the slave modport is the target.
interface i2c_reg_slave_if;
    logic scl;
    logic sda_in;
    logic sda_oe;
    logic sda_out;

    modport master (
        output scl,
        output sda_in,
        input  sda_oe,
        input  sda_out
    );

    modport slave (
        input  scl,
        input  sda_in,
        output sda_oe,
        output sda_out
    );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C register target: RO bytes sampled from the fabric, RW control bytes held here.
// Optional SCL-low bus timeout is compiled in with `define I2C_SCL_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free or not addressed, SDA released
// ADDR     | shifting in the 7-bit address plus R/W bit
// ADDR_ACK | driving ACK for a matching address
// PTR      | shifting in the register pointer
// PTR_ACK  | driving ACK for the pointer byte
// WR_DATA  | shifting in a write data byte
// WR_ACK   | ACK/NACK of a write byte; commit on the closing SCL fall
// TX       | driving a read byte MSB first
// MACK     | released SDA, sampling the master ACK/NACK
module i2c_reg_slave #(
    parameter logic [6:0] I2C_ADDR       = 7'h64,
    parameter int         NUM_RO         = 3,
    parameter int         NUM_RW         = 2,
    parameter logic [7:0] RW_RESET       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    i2c_reg_slave_if.slave      bus,
    input  logic [8*NUM_RO-1:0] ro_data,
    output logic [8*NUM_RW-1:0] rw_data,
    output logic                wr_strobe,
    output logic [7:0]          wr_addr,
    output logic                busy,
    output logic                timeout
);

    localparam logic [7:0] RW_BASE   = 8'(NUM_RO);
    localparam logic [7:0] LAST_ADDR = 8'(NUM_RO + NUM_RW - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        TX,
        MACK
    } state_t;

    state_t                   state;
    logic [7:0]               shreg;
    logic [7:0]               ptr;
    logic [3:0]               bit_cnt;
    logic                     rd_mode;
    logic                     wr_ok;
    logic                     sda_oe;
    logic [NUM_RW-1:0][7:0]   rw_regs;

    logic [2:0]               scl_sync;
    logic [2:0]               sda_sync;
    logic                     scl_s;
    logic                     sda_s;
    logic                     scl_rise;
    logic                     scl_fall;
    logic                     start_det;
    logic                     stop_det;
    logic                     to_fire;

    logic [7:0]               ptr_inc;
    logic                     ptr_is_rw;
    logic [7:0]               rd_addr;
    logic [7:0]               rd_byte;

    assign bus.sda_oe  = sda_oe;
    assign bus.sda_out = 1'b0;
    assign rw_data     = rw_regs;

    // Two sync flops plus one history flop; reset to the idle-bus level so no
    // phantom edges appear when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], bus.scl};
            sda_sync <= {sda_sync[1:0], bus.sda_in};
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_det = ~sda_sync[1] & sda_sync[2] & scl_sync[1] & scl_sync[2];
    assign stop_det  = sda_sync[1] & ~sda_sync[2] & scl_sync[1] & scl_sync[2];

    // Out-of-range pointers step to 0 so a read of 0xFF is followed by address 0.
    assign ptr_inc   = (ptr >= LAST_ADDR) ? 8'd0 : ptr + 8'd1;
    assign ptr_is_rw = (ptr >= RW_BASE) && (ptr <= LAST_ADDR);
    assign rd_addr   = (state == MACK) ? ptr_inc : ptr;

    always_comb begin
        rd_byte = 8'hFF;
        for (int k = 0; k < NUM_RO; k++) begin
            if (rd_addr == 8'(k)) rd_byte = ro_data[8*k +: 8];
        end
        for (int k = 0; k < NUM_RW; k++) begin
            if (rd_addr == RW_BASE + 8'(k)) rd_byte = rw_regs[k];
        end
    end

`ifdef I2C_SCL_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign to_fire = busy && !scl_s && (to_cnt == 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= 32'(TIMEOUT_CYCLES);
            timeout <= 1'b0;
        end else begin
            timeout <= to_fire;
            if (!busy || scl_s) begin
                to_cnt <= 32'(TIMEOUT_CYCLES);
            end else if (to_cnt != 32'd0) begin
                to_cnt <= to_cnt - 32'd1;
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= 8'h00;
            ptr       <= 8'h00;
            bit_cnt   <= 4'd0;
            rd_mode   <= 1'b0;
            wr_ok     <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            rw_regs   <= {NUM_RW{RW_RESET}};
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (to_fire) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                    ADDR, PTR, WR_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == I2C_ADDR) begin
                                    state   <= ADDR_ACK;
                                    rd_mode <= shreg[0];
                                    busy    <= 1'b1;
                                    sda_oe  <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr    <= shreg;
                                state  <= PTR_ACK;
                                sda_oe <= 1'b1;
                            end else begin
                                wr_ok  <= ptr_is_rw;
                                sda_oe <= ptr_is_rw;
                                state  <= WR_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rd_mode) begin
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                                state  <= TX;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WR_DATA;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WR_DATA;
                            if (wr_ok) begin
                                for (int k = 0; k < NUM_RW; k++) begin
                                    if (ptr == RW_BASE + 8'(k)) rw_regs[k] <= shreg;
                                end
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                ptr       <= ptr_inc;
                            end
                        end
                    end
                    TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= MACK;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    MACK: begin
                        // bit_cnt doubles as the "master acknowledged" flag here.
                        if (scl_rise) begin
                            if (sda_s) begin
                                ptr   <= ptr_inc;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            ptr     <= ptr_inc;
                            shreg   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 4'd0;
                            state   <= TX;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master, ACK/read-data and
// write-commit scoreboards, reset and (optional) SCL timeout checks.
module tb_i2c_reg_slave;

    logic        clk;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic [23:0] ro_data;
    logic [15:0] rw_data;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic        busy;
    logic        timeout;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] wr_exp_q[$];

    i2c_reg_slave_if bus_if ();

    assign bus_if.scl    = scl_m;
    assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

    i2c_reg_slave #(
        .I2C_ADDR       (7'h64),
        .NUM_RO         (3),
        .NUM_RW         (2),
        .RW_RESET       (8'h00),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .ro_data   (ro_data),
        .rw_data   (rw_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commit monitor: every wr_strobe must match the next expected write address.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (wr_exp_q.size() == 0) check("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
            else check("wr_addr", 32'(wr_addr), 32'(wr_exp_q.pop_front()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        wait_clk(5);
        sda_m = b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        r = bus_if.sda_in;
        wait_clk(5);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(8);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    // exp_ack: 0 = target must ACK, 1 = target must leave SDA high.
    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic r;
        exp_q.push_back({7'd0, exp_ack});
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        check(tag_q.pop_front(), 32'(r), 32'(exp_q.pop_front()));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack, input string tag);
        logic       r;
        logic [7:0] got;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            got[i] = r;
        end
        bit_xfer(nack, r);
        check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
    endtask

    initial begin
        logic       r;
        logic [3:0] nib;
        rst_n   = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        ro_data = {8'h33, 8'h22, 8'h11};
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);

        check("rst_sda_oe", 32'(bus_if.sda_oe), 32'd0);
        check("rst_sda_out", 32'(bus_if.sda_out), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_rw_data", 32'(rw_data), 32'h0000);

        // 1: two writes starting at the first RW register, pointer wraps to 0
        i2c_start();
        write_byte(8'hC8, 1'b0, "t1_addr_ack");
        check("t1_busy_after_match", 32'(busy), 32'd1);
        write_byte(8'h03, 1'b0, "t1_ptr_ack");
        wr_exp_q.push_back(8'd3);
        write_byte(8'h5A, 1'b0, "t1_data0_ack");
        wr_exp_q.push_back(8'd4);
        write_byte(8'hA5, 1'b0, "t1_data1_ack");
        i2c_stop();
        check("t1_rw_data", 32'(rw_data), 32'hA55A);
        check("t1_wr_addr_last", 32'(wr_addr), 32'd4);
        check("t1_busy_after_stop", 32'(busy), 32'd0);
        i2c_start();
        write_byte(8'hC9, 1'b0, "t1_rd_addr_ack");
        read_byte(8'h11, 1'b1, "t1_ptr_wrapped_to_0");
        i2c_stop();

        // 2: pointer write, repeated START, sequential read of all RO bytes
        i2c_start();
        write_byte(8'hC8, 1'b0, "t2_addr_ack");
        write_byte(8'h00, 1'b0, "t2_ptr_ack");
        i2c_start();
        write_byte(8'hC9, 1'b0, "t2_rd_addr_ack");
        read_byte(8'h11, 1'b0, "t2_rd0");
        read_byte(8'h22, 1'b0, "t2_rd1");
        read_byte(8'h33, 1'b1, "t2_rd2");
        i2c_stop();
        check("t2_busy_after_stop", 32'(busy), 32'd0);

        // 3: foreign address is ignored
        i2c_start();
        write_byte(8'hCA, 1'b1, "t3_wrong_addr_nack");
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_sda_oe", 32'(bus_if.sda_oe), 32'd0);
        i2c_stop();

        // 4: write into an RO register is refused and leaves the pointer alone
        i2c_start();
        write_byte(8'hC8, 1'b0, "t4_addr_ack");
        write_byte(8'h01, 1'b0, "t4_ptr_ack");
        write_byte(8'h77, 1'b1, "t4_ro_write_nack");
        i2c_start();
        write_byte(8'hC9, 1'b0, "t4_rd_addr_ack");
        read_byte(8'h22, 1'b1, "t4_ro_readback");
        i2c_stop();
        check("t4_rw_data_unchanged", 32'(rw_data), 32'hA55A);

        // 5: out-of-range read returns 0xFF, then address 0
        i2c_start();
        write_byte(8'hC8, 1'b0, "t5_addr_ack");
        write_byte(8'h09, 1'b0, "t5_oor_ptr_ack");
        i2c_start();
        write_byte(8'hC9, 1'b0, "t5_rd_addr_ack");
        read_byte(8'hFF, 1'b0, "t5_rd_oor");
        read_byte(8'h11, 1'b1, "t5_rd_after_oor");
        i2c_stop();

        // 6: reset while the target drives a 0 in the middle of a read byte
        i2c_start();
        write_byte(8'hC8, 1'b0, "t6_addr_ack");
        write_byte(8'h00, 1'b0, "t6_ptr_ack");
        i2c_start();
        write_byte(8'hC9, 1'b0, "t6_rd_addr_ack");
        nib = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            nib[i] = r;
        end
        check("t6_first_nibble", 32'(nib), 32'h1);
        wait_clk(6);
        check("t6_sda_driven_low", 32'(bus_if.sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_sda_oe_async_reset", 32'(bus_if.sda_oe), 32'd0);
        check("t6_rw_data_reset", 32'(rw_data), 32'h0000);
        check("t6_busy_reset", 32'(busy), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(5);

        // SCL held low mid-read
        i2c_start();
        write_byte(8'hC8, 1'b0, "t7_addr_ack");
        write_byte(8'h00, 1'b0, "t7_ptr_ack");
        i2c_start();
        write_byte(8'hC9, 1'b0, "t7_rd_addr_ack");
        bit_xfer(1'b1, r);
        check("t7_rd_bit7", 32'(r), 32'd0);
`ifdef I2C_SCL_TIMEOUT_EN
        begin
            logic seen;
            logic oe_mid;
            int   cyc;
            seen   = 1'b0;
            oe_mid = 1'b0;
            cyc    = 0;
            for (int i = 1; i <= 200 && !seen; i++) begin
                @(negedge clk);
                if (i == 10) oe_mid = bus_if.sda_oe;
                if (timeout) begin
                    seen = 1'b1;
                    cyc  = i;
                end
            end
            check("t7_sda_driven_before_timeout", 32'(oe_mid), 32'd1);
            check("t7_timeout_seen", 32'(seen), 32'd1);
            check("t7_timeout_window", 32'(cyc >= 100 && cyc <= 110), 32'd1);
            check("t7_sda_oe_released", 32'(bus_if.sda_oe), 32'd0);
            check("t7_busy_cleared", 32'(busy), 32'd0);
            @(negedge clk);
            check("t7_timeout_single_pulse", 32'(timeout), 32'd0);
        end
`else
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                if (timeout) seen = 1'b1;
            end
            check("t7_no_timeout", 32'(seen), 32'd0);
            check("t7_still_busy", 32'(busy), 32'd1);
        end
`endif
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(5);
        check("end_wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
Parametrised I2C target with a byte-addressed register map and both read and write transfers. Low registers are read-only and sampled from fabric inputs. High registers are read-write control bytes held inside the block and driven out to the fabric. The block sits between the chip SDA/SCL pads (open-drain) and the design core. It supports a register pointer, auto-increment, repeated START and STOP detection.

Parameters:
I2C_ADDR, 7'h64, 7-bit target address.
NUM_RO, 3, read-only register count, addresses 0..NUM_RO-1.
NUM_RW, 2, read-write register count, addresses NUM_RO..NUM_RO+NUM_RW-1.
RW_RESET, 8'h00, reset value of every RW register.
TIMEOUT_CYCLES, 65535, clk cycles of SCL-low before the bus is abandoned (optional feature only).

Ports:
clk  in  1  system clock; must be at least 8x the SCL frequency.
rst_n  in  1  asynchronous active-low reset.
scl  in  1  I2C clock from the pad.
sda_in  in  1  I2C data from the pad.
sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
sda_out  out  1  constant 0.
ro_data  in  8*NUM_RO  read-only bytes; byte k is [8k+7:8k].
rw_data  out  8*NUM_RW  current RW register contents; byte k is address NUM_RO+k.
wr_strobe  out  1  one-clk pulse when an RW byte is committed.
wr_addr  out  8  register address of the last commit.
busy  out  1  high from address match until STOP or return to IDLE.
timeout  out  1  one-clk pulse on SCL timeout; constant 0 when the feature is compiled out.

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_addr=0, busy=0, timeout=0, every RW byte=RW_RESET, pointer=0, state=IDLE.
- Synchronisation: scl and sda_in each pass through 2 flops, plus 1 flop for edge detect. rise/fall are single-clk pulses.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - START in any state: go to ADDR, bit count=0, sda_oe=0. This covers repeated START.
  - STOP in any state: go to IDLE, sda_oe=0, busy=0. The pointer is retained.
- Sampling: SDA is sampled on SCL rise. sda_oe changes only on the clk after SCL fall.
- IDLE: sda_oe=0; wait for START.
- ADDR: shift 8 bits MSB first.
  - If bits[7:1]==I2C_ADDR: go to ADDR_ACK, latch R/W, set busy=1.
  - Otherwise: go to IDLE; no ACK is driven.
- ADDR_ACK: pull SDA for exactly one SCL period (fall to fall).
  - W: go to PTR.
  - R: load shreg from the byte at pointer, then go to TX.
- PTR: receive 8 bits into the pointer; go to PTR_ACK. Always ACK, even if the pointer is out of range. Then go to WR_DATA.
- WR_DATA: receive 8 bits, then WR_ACK.
  - Pointer addresses an RW register: ACK, write the byte on the 9th SCL fall, pulse wr_strobe, set wr_addr=pointer, increment pointer.
  - Pointer is RO or >= NUM_RO+NUM_RW: NACK (release SDA), no write, pointer unchanged.
  - After WR_ACK, return to WR_DATA.
- TX: drive shreg MSB first; sda_oe = ~bit.
  - After the 8th SCL fall: release SDA and go to MACK.
  - Read data is latched at load time. Later ro_data changes do not affect a byte in flight.
- MACK: sample on SCL rise.
  - ACK(0): increment pointer, reload shreg, return to TX.
  - NACK(1): go to IDLE; pointer is incremented once.
- Pointer arithmetic:
  - Increment wraps from NUM_RO+NUM_RW-1 to 0.
  - Out-of-range pointers do not increment on writes.
  - Reading an out-of-range pointer returns 8'hFF and sets pointer=0 for the next byte.
- Simultaneous: a START/STOP detected on the same clk as an SCL edge takes precedence over the data action.
- Reset mid-transfer: SDA is released immediately (asynchronous) and RW registers return to RW_RESET.

Optional Feature:
Macro I2C_SCL_TIMEOUT_EN.
- Defined: a counter counts clks while busy=1 and SCL is low, and clears whenever SCL is high. When it reaches TIMEOUT_CYCLES: release SDA, go to IDLE, clear busy, pulse timeout for 1 clk.
- Undefined: no counter; timeout is tied to 0; the block waits indefinitely.

Test Plan:
1. Write: START, 0xC8, ptr 0x03, 0x5A, 0xA5, STOP -> all ACKed. rw_data = {0xA5,0x5A}. Two wr_strobe pulses with wr_addr 3 then 4. Final pointer=0 (wrap).
2. Read: ro_data = {0x33,0x22,0x11}; write ptr 0x00, repeated START, 0xC9, read 3 bytes ACK,ACK,NACK -> bus data 0x11, 0x22, 0x33; busy falls at STOP.
3. Wrong address: 0xCA -> no ACK (SDA high on 9th clock); state IDLE; no wr_strobe.
4. Write to RO: ptr 0x01, data 0x77 -> data byte NACKed; no wr_strobe; RO readback unchanged.
5. Out-of-range read: ptr 0x09, read 2 bytes -> 0xFF, then byte at address 0.
6. Reset pulse during TX bit 4 -> sda_oe=0 within 0 clks; rw_data = RW_RESET. With I2C_SCL_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold SCL low 101 clks mid-read -> timeout pulse, sda_oe=0.
